// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_buffer
// Description : Byte FIFO feeding an 8N1-style UART serializer (LSB first).
// Revision    : 1.0
// ============================================================================

module uart_tx_buffer #(
    parameter int SYS_CLK_FREQ    = 100000000,
    parameter int UART_BAUD_RATE  = 115200,
    parameter int BYTE_SIZE       = 8,
    parameter int FIFO_SIZE       = 16,
    parameter int FIFO_INDEX_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [BYTE_SIZE-1:0] wr_data,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 drop,
    output logic                 Tx
);

    localparam int c_BAUD_DIV = SYS_CLK_FREQ / UART_BAUD_RATE;
    localparam int c_BAUD_W   = (c_BAUD_DIV > 1) ? $clog2(c_BAUD_DIV) : 1;
    localparam int c_BIT_W    = (BYTE_SIZE > 1) ? $clog2(BYTE_SIZE) : 1;
    localparam logic [c_BAUD_W-1:0]        c_BAUD_LAST = c_BAUD_W'(c_BAUD_DIV - 1);
    localparam logic [c_BIT_W-1:0]         c_BIT_LAST  = c_BIT_W'(BYTE_SIZE - 1);
    localparam logic [FIFO_INDEX_SIZE:0]   c_COUNT_MAX = (FIFO_INDEX_SIZE + 1)'(FIFO_SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                     state_q,    state_d;
    logic [FIFO_INDEX_SIZE:0]   count_q,    count_d;
    logic [FIFO_INDEX_SIZE-1:0] wr_ptr_q,   wr_ptr_d;
    logic [FIFO_INDEX_SIZE-1:0] rd_ptr_q,   rd_ptr_d;
    logic [c_BAUD_W-1:0]        baud_cnt_q, baud_cnt_d;
    logic [c_BIT_W-1:0]         bit_idx_q,  bit_idx_d;
    logic [BYTE_SIZE-1:0]       shift_q,    shift_d;
    logic                       tx_q,       tx_d;
    logic                       drop_q,     drop_d;
    logic [BYTE_SIZE-1:0]       mem_q [FIFO_SIZE];

    logic w_push;
    logic w_pop;
    logic w_baud_done;

    assign full        = (count_q == c_COUNT_MAX);
    assign empty       = (count_q == '0);
    assign busy        = (state_q != S_IDLE);
    assign drop        = drop_q;
    assign Tx          = tx_q;
    assign w_push      = wr_en && !full;
    assign w_baud_done = (baud_cnt_q == c_BAUD_LAST);

    // Serializer next-state; a pop is requested only from IDLE or at the end of STOP.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        w_pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    w_pop      = 1'b1;
                    shift_d    = mem_q[rd_ptr_q];
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    baud_cnt_d = '0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + c_BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    baud_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    if (bit_idx_q == c_BIT_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + c_BIT_W'(1);
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + c_BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    if (!empty) begin
                        w_pop   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + c_BAUD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tx follows the current state one cycle later, so the first low bit lands two edges after a write.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        drop_d   = wr_en && full;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + FIFO_INDEX_SIZE'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_INDEX_SIZE'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (FIFO_INDEX_SIZE + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_INDEX_SIZE + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_buffer
// Description : Randomized scoreboard bench for uart_tx_buffer with a serial-line decoder.
// Revision    : 1.0
// ============================================================================

module tb_uart_tx_buffer;

    localparam int SYS_CLK = 1050;
    localparam int BAUD    = 100;
    localparam int BS      = 8;
    localparam int FS      = 16;
    localparam int FIS     = 4;
    localparam int B       = SYS_CLK / BAUD;
    localparam int FRAME   = (BS + 2) * B;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [BS-1:0] wr_data = '0;
    logic          full, empty, busy, drop, tx;

    always #5 clk = ~clk;

    uart_tx_buffer #(
        .SYS_CLK_FREQ   (SYS_CLK),
        .UART_BAUD_RATE (BAUD),
        .BYTE_SIZE      (BS),
        .FIFO_SIZE      (FS),
        .FIFO_INDEX_SIZE(FIS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .full   (full),
        .empty  (empty),
        .busy   (busy),
        .drop   (drop),
        .Tx     (tx)
    );

    // Reference: occupancy and the edge at which the serializer is next free.
    int            cyc = 0;
    int            m_count = 0;
    int            m_ready = 0;
    bit            exp_drop = 1'b0;
    bit            rst_seen = 1'b0;
    bit            m_full, m_acc, m_pop;
    int            d_flush = 0;
    int            s_flush = 0;
    logic [BS-1:0] exp_data[$];
    int            exp_start[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_count  = 0;
            m_ready  = 0;
            exp_drop = 1'b0;
            rst_seen = 1'b1;
            d_flush  = exp_data.size();
            s_flush  = exp_start.size();
        end else begin
            rst_seen = 1'b0;
            m_full   = (m_count == FS);
            m_acc    = wr_en && !m_full;
            m_pop    = (m_count > 0) && (cyc >= m_ready);
            exp_drop = wr_en && m_full;
            if (m_acc) exp_data.push_back(wr_data);
            if (m_pop) begin
                m_ready = cyc + FRAME;
                exp_start.push_back(cyc + 1);
            end
            m_count = m_count + int'(m_acc) - int'(m_pop);
        end
    end

    // Monitor: flag checks every cycle plus serial-frame decoding.
    int         checks = 0;
    int         failures = 0;
    int         d_rd = 0;
    int         s_rd = 0;
    bit         in_frame = 1'b0;
    int         bit_no = 0;
    int         cnt = 0;
    logic       cur = 1'b1;
    logic [9:0] bits = '0;
    bit         final_req = 1'b0;
    bit         final_done = 1'b0;
    bit         timeout_hit = 1'b0;
    logic [BS-1:0] got_byte;

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        checks = checks + 1;
        if (!ok) begin
            failures = failures + 1;
            $display("FAIL %s: actual=%0d required=%0d cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk(full  == (m_count == FS), "full",  int'(full),  int'(m_count == FS));
            chk(empty == (m_count == 0),  "empty", int'(empty), int'(m_count == 0));
            chk(busy  == (m_ready > cyc), "busy",  int'(busy),  int'(m_ready > cyc));
            chk(drop  == exp_drop,        "drop",  int'(drop),  int'(exp_drop));
            if (rst_seen) begin
                in_frame = 1'b0;
                d_rd     = d_flush;
                s_rd     = s_flush;
                chk(tx == 1'b1, "tx_after_reset", int'(tx), 1);
            end else begin
                if (in_frame) begin
                    if (cnt == B) begin
                        bits[bit_no] = cur;
                        bit_no       = bit_no + 1;
                        if (bit_no == BS + 2) begin
                            in_frame = 1'b0;
                            got_byte = bits[BS:1];
                            chk(bits[BS+1] == 1'b1, "stop_bit", int'(bits[BS+1]), 1);
                            if (d_rd < exp_data.size()) begin
                                chk(got_byte == exp_data[d_rd], "frame_data", int'(got_byte), int'(exp_data[d_rd]));
                                d_rd = d_rd + 1;
                            end else begin
                                chk(1'b0, "unexpected_frame", int'(got_byte), -1);
                            end
                        end else begin
                            cur = tx;
                            cnt = 1;
                        end
                    end else begin
                        chk(tx == cur, "bit_stable", int'(tx), int'(cur));
                        cnt = cnt + 1;
                    end
                end
                if (!in_frame) begin
                    if (tx == 1'b0) begin
                        if (s_rd < exp_start.size()) begin
                            chk(exp_start[s_rd] == cyc, "start_time", cyc, exp_start[s_rd]);
                            s_rd = s_rd + 1;
                        end else begin
                            chk(1'b0, "unexpected_start", cyc, -1);
                        end
                        in_frame = 1'b1;
                        bit_no   = 0;
                        cnt      = 1;
                        cur      = 1'b0;
                    end else if (s_rd < exp_start.size() && exp_start[s_rd] < cyc) begin
                        chk(1'b0, "missing_start", cyc, exp_start[s_rd]);
                        s_rd = s_rd + 1;
                    end
                end
            end
            if (final_req && !final_done) begin
                chk(!timeout_hit, "drain_timeout", int'(timeout_hit), 0);
                chk(d_rd == exp_data.size(), "bytes_delivered", d_rd, exp_data.size());
                chk(s_rd == exp_start.size(), "starts_seen", s_rd, exp_start.size());
                final_done = 1'b1;
            end
        end
    end

    task automatic step(input bit we, input logic [BS-1:0] d);
        @(negedge clk);
        wr_en   = we;
        wr_data = d;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 40 * FRAME; i++) begin
            step(1'b0, '0);
            if (m_count == 0 && cyc > m_ready + 1 && !in_frame) break;
        end
        if (i >= 40 * FRAME) timeout_hit = 1'b1;
        repeat (3) step(1'b0, '0);
    endtask

    task automatic wait_edge_before_ready();
        for (int i = 0; i < 2 * FRAME && cyc != m_ready - 1; i++) step(1'b0, '0);
    endtask

    initial begin
        int s;
        // Writes during reset must be ignored.
        rst = 1'b1;
        repeat (3) step(1'b1, 8'h77);
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        repeat (4) step(1'b0, '0);

        step(1'b1, 8'hA5);
        drain();

        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        drain();

        // Overflow: one byte in flight plus 17 more writes.
        step(1'b1, 8'h10);
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h20 + i));
        drain();

        // Wrap-around with interleaved writes; never write into a full FIFO.
        for (int v = 0; v < 40; v++) begin
            repeat ($urandom_range(0, 3)) step(1'b0, '0);
            for (int i = 0; i < 4 * FRAME && m_count == FS; i++) step(1'b0, '0);
            step(1'b1, 8'(v));
        end
        drain();

        // Push coinciding with a pop at the end of STOP, count = 3.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i));
        wait_edge_before_ready();
        step(1'b1, 8'h55);
        step(1'b0, '0);
        drain();

        // Full FIFO: pop in the same cycle still drops the write.
        for (int i = 0; i < FS + 1; i++) step(1'b1, 8'(8'h60 + i));
        wait_edge_before_ready();
        step(1'b1, 8'hEE);
        step(1'b0, '0);
        drain();

        // Mid-frame reset during data bit 4 with 5 bytes queued.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i));
        step(1'b0, '0);
        s = exp_start[exp_start.size() - 1];
        for (int i = 0; i < 2 * FRAME && cyc < s + 5 * B + 3; i++) step(1'b0, '0);
        @(negedge clk);
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h99;
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        repeat (3 * FRAME) step(1'b0, '0);

        // Random traffic, including sustained overflow.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 12), 8'($urandom));
        end
        drain();

        final_req = 1'b1;
        for (int i = 0; i < 10 && !final_done; i++) @(negedge clk);
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 The block SHALL have parameter SYS_CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter UART_BAUD_RATE, default 115200, serial bit rate.
REQ-003 The block SHALL have parameter BYTE_SIZE, default 8, data bits per frame.
REQ-004 The block SHALL have parameter FIFO_SIZE, default 16, FIFO entries; a power of two.
REQ-005 The block SHALL have parameter FIFO_INDEX_SIZE, default 4, equal to log2(FIFO_SIZE).
REQ-006 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-008 The block SHALL have port wr_en, input, 1, byte-write request from the memory-mapped IO path.
REQ-009 The block SHALL have port wr_data, input, BYTE_SIZE, byte to transmit.
REQ-010 The block SHALL have port full, output, 1, FIFO holds FIFO_SIZE entries.
REQ-011 The block SHALL have port empty, output, 1, FIFO holds 0 entries.
REQ-012 The block SHALL have port busy, output, 1, serializer not in IDLE.
REQ-013 The block SHALL have port drop, output, 1, one-cycle pulse when a write was discarded.
REQ-014 The block SHALL have port Tx, output, 1, serial line driven to the top-level Tx pin.

Function
REQ-015 BAUD_DIV SHALL equal SYS_CLK_FREQ/UART_BAUD_RATE (integer division; 868 at defaults); every bit SHALL last exactly BAUD_DIV cycles.
REQ-016 Writes SHALL be accepted when wr_en=1 and full=0; the byte is stored at the write pointer and count increments at the next edge.
REQ-017 wr_en=1 with full=1 SHALL discard the byte, leave FIFO unchanged, and assert drop for exactly the next cycle.
REQ-018 full and empty SHALL be combinational from a registered count (width FIFO_INDEX_SIZE+1, range 0..FIFO_SIZE).
REQ-019 Read and write pointers SHALL be FIFO_INDEX_SIZE bits and wrap from FIFO_SIZE-1 to 0.
REQ-020 An accepted push and a pop in the same cycle SHALL leave count unchanged; a pop from a full FIFO in the same cycle as wr_en still drops the write (full is evaluated before the pop).
REQ-021 The serializer SHALL be a four-state FSM: IDLE, START, DATA, STOP.
REQ-022 IDLE: Tx=1; if empty=0, pop the head byte into a shift register, clear baud counter and bit index, go to START.
REQ-023 START: Tx=0 for BAUD_DIV cycles, then go to DATA.
REQ-024 DATA: Tx=shift-register bit 0 (LSB first); after each BAUD_DIV cycles shift right and increment bit index; after BYTE_SIZE bits go to STOP.
REQ-025 STOP: Tx=1 for BAUD_DIV cycles; then, if empty=0, pop and go directly to START (no idle gap); else go to IDLE.
REQ-026 Tx SHALL be registered; a byte written into an empty FIFO with FSM in IDLE at edge N SHALL be popped at edge N+1 and Tx SHALL be 0 from edge N+2.
REQ-027 One frame SHALL occupy exactly (BYTE_SIZE+2)*BAUD_DIV cycles (8680 at defaults).
REQ-028 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-029 Writes SHALL be accepted in every FSM state; transmission never blocks the write port except via full.

Reset
REQ-030 On rst=1 at a clock edge: FSM=IDLE, count=0, pointers=0, baud counter=0, bit index=0, Tx=1, drop=0; hence empty=1, full=0, busy=0.
REQ-031 rst asserted mid-frame SHALL abort the frame, drive Tx=1 from the next edge, and discard all queued bytes.
REQ-032 wr_en during a cycle with rst=1 SHALL be ignored.

Verification
REQ-033 Single byte: after reset, write 0xA5 -> Tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 868 cycles; first low at write edge+2; busy falls after 8680 cycles.
REQ-034 Back-to-back: write 0x00 then 0xFF on consecutive cycles -> two frames with no idle gap; second start bit begins exactly 8680 cycles after the first.
REQ-035 Overflow: with FSM busy on byte 0, write 17 more bytes while the serializer holds its first frame -> 16 accepted, full=1, 17th write gives one-cycle drop=1; drained bytes arrive in write order.
REQ-036 Wrap-around: push/pop 40 bytes (values 0..39) with interleaved writes -> all 40 transmitted in order, no drop, empty=1 at end.
REQ-037 Simultaneous push/pop: FIFO count=3 and STOP ends popping while wr_en=1 -> count stays 3 next cycle.
REQ-038 Mid-frame reset: assert rst during DATA bit 4 with 5 bytes queued -> next edge Tx=1, busy=0, empty=1; no further start bits until a new write.
